// File: rtl/life_gen_sequencer.sv
`timescale 1ns/1ps
// Life grid load sequencer: seed / paced run / single-step / hold, plus a generation counter.
// Optional freeze detection (stop when the grid no longer changes) is enabled by LIFE_FREEZE_DETECT_EN.
module life_gen_sequencer #(
  parameter int BASE_DIV = 25_000_000,
  parameter int DIV_W    = 32,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [1:0]       speed,
  input  logic             grid_changed,
  output logic [1:0]       active,
  output logic             grid_we,
  output logic [GEN_W-1:0] gen_count,
  output logic             frozen
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    FROZEN = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] period_m1;
  logic             period_done;
  logic             tick;
  logic             tick_q;
  logic             frozen_q;
  logic             freeze_hit;
  logic             seed_entry;

  assign period_m1   = (DIV_W'(BASE_DIV) << speed) - DIV_W'(1);
  // ">=" so that lowering speed mid-period fires on the next edge instead of wrapping.
  assign period_done = (div_cnt >= period_m1);
  assign seed_entry  = (state_nxt == SEED) && (state != SEED);

`ifdef LIFE_FREEZE_DETECT_EN
  assign freeze_hit = ~grid_changed;
`else
  logic unused_grid_changed;
  assign unused_grid_changed = grid_changed;
  assign freeze_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    case (state)
      IDLE: begin
        if (mode == 2'b11)      state_nxt = SEED;
        else if (mode == 2'b01) state_nxt = RUN;
        else if (step)          state_nxt = STEP;
      end
      SEED: begin
        if (mode != 2'b11) state_nxt = IDLE;
      end
      RUN: begin
        if (mode != 2'b01) begin
          state_nxt = IDLE;
        end else if (period_done) begin
          if (freeze_hit) state_nxt = FROZEN;
          else            tick      = 1'b1;
        end
      end
      STEP: state_nxt = IDLE;
      FROZEN: begin
        if (mode == 2'b11)      state_nxt = SEED;
        else if (mode == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_q    <= 1'b0;
      gen_count <= '0;
      frozen_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick_q <= tick;

      if ((state != RUN) || tick) div_cnt <= '0;
      else                        div_cnt <= div_cnt + DIV_W'(1);

      if (seed_entry)                    gen_count <= '0;
      else if (tick || (state == STEP))  gen_count <= gen_count + GEN_W'(1);

      if (seed_entry)                          frozen_q <= 1'b0;
      else if (state_nxt == FROZEN)            frozen_q <= 1'b1;
      else if ((state == STEP) && freeze_hit)  frozen_q <= 1'b1;
    end
  end

  always_comb begin
    active  = 2'b00;
    grid_we = 1'b0;
    case (state)
      SEED: begin
        active  = 2'b11;
        grid_we = 1'b1;
      end
      RUN: begin
        active  = 2'b01;
        grid_we = tick_q;
      end
      STEP: begin
        active  = 2'b01;
        grid_we = 1'b1;
      end
      default: begin
        active  = 2'b00;
        grid_we = 1'b0;
      end
    endcase
  end

  assign frozen = frozen_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
`timescale 1ns/1ps
// Bench for life_gen_sequencer: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a cycle-counting behavioural model.
module tb_life_gen_sequencer;

  localparam int BASE_DIV = 4;
  localparam int DIV_W    = 8;
  localparam int GEN_W    = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_SEED   = 1;
  localparam int PH_RUN    = 2;
  localparam int PH_STEP   = 3;
  localparam int PH_FROZEN = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             step = 1'b0;
  logic [1:0]       speed = 2'b00;
  logic             grid_changed = 1'b1;
  logic [1:0]       active;
  logic             grid_we;
  logic [GEN_W-1:0] gen_count;
  logic             frozen;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  life_gen_sequencer #(
    .BASE_DIV(BASE_DIV),
    .DIV_W(DIV_W),
    .GEN_W(GEN_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .step(step),
    .speed(speed),
    .grid_changed(grid_changed),
    .active(active),
    .grid_we(grid_we),
    .gen_count(gen_count),
    .frozen(frozen)
  );

  always #5 clk = ~clk;

`ifdef LIFE_FREEZE_DETECT_EN
  localparam bit FREEZE_EN = 1'b1;
`else
  localparam bit FREEZE_EN = 1'b0;
`endif

  // Behavioural model: phase of operation, RUN edges since the last load, pending load flag.
  int m_phase = PH_IDLE;
  int m_since = 0;
  int m_gen = 0;
  bit m_load = 1'b0;
  bit m_frozen = 1'b0;

  function automatic int period_of(input logic [1:0] s);
    return BASE_DIV * (1 << s);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = PH_IDLE; m_since = 0; m_gen = 0; m_load = 1'b0; m_frozen = 1'b0;
    end else begin
      m_load = 1'b0;
      case (m_phase)
        PH_IDLE: begin
          if (mode == 2'd3) begin m_phase = PH_SEED; m_gen = 0; m_frozen = 1'b0; end
          else if (mode == 2'd1) begin m_phase = PH_RUN; m_since = 0; end
          else if (step) m_phase = PH_STEP;
        end
        PH_SEED: if (mode != 2'd3) m_phase = PH_IDLE;
        PH_RUN: begin
          if (mode != 2'd1) m_phase = PH_IDLE;
          else begin
            m_since = m_since + 1;
            if (m_since >= period_of(speed)) begin
              m_since = 0;
              if (FREEZE_EN && !grid_changed) begin
                m_phase = PH_FROZEN; m_frozen = 1'b1;
              end else begin
                m_load = 1'b1; m_gen = (m_gen + 1) % (1 << GEN_W);
              end
            end
          end
        end
        PH_STEP: begin
          m_gen = (m_gen + 1) % (1 << GEN_W);
          if (FREEZE_EN && !grid_changed) m_frozen = 1'b1;
          m_phase = PH_IDLE;
        end
        PH_FROZEN: begin
          if (mode == 2'd3) begin m_phase = PH_SEED; m_gen = 0; m_frozen = 1'b0; end
          else if (mode == 2'd0) m_phase = PH_IDLE;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  function automatic int exp_active();
    if (m_phase == PH_SEED) return 3;
    if (m_phase == PH_RUN || m_phase == PH_STEP) return 1;
    return 0;
  endfunction

  function automatic int exp_we();
    if (m_phase == PH_SEED || m_phase == PH_STEP) return 1;
    if (m_phase == PH_RUN) return int'(m_load);
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_active", 32'(active), 32'(exp_active()));
      check("model_grid_we", 32'(grid_we), 32'(exp_we()));
      check("model_gen_count", 32'(gen_count), 32'(m_gen));
      check("model_frozen", 32'(frozen), 32'(m_frozen));
    end
  end

  // Called at a negedge; returns number of grid_we samples and the index of the first one.
  task automatic run_cycles(input int n, input logic [1:0] md, input logic [1:0] sp,
                            input logic gc, output int we_cnt, output int first_idx);
    mode = md; speed = sp; grid_changed = gc;
    we_cnt = 0; first_idx = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (grid_we === 1'b1) begin
        if (first_idx < 0) first_idx = i;
        we_cnt++;
      end
    end
  endtask

  task automatic apply_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    mode = 2'b00; step = 1'b0; speed = 2'b00; grid_changed = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_n;
    int first;
    logic [1:0] mode_tab [6];
    mode_tab = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2};

    #1 reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_active", 32'(active), 32'd0);
    check("rst_grid_we", 32'(grid_we), 32'd0);
    check("rst_gen_count", 32'(gen_count), 32'd0);
    check("rst_frozen", 32'(frozen), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of RUN
    run_cycles(21, 2'd1, 2'd0, 1'b1, we_n, first);
    check("run_gen5", 32'(gen_count), 32'd5);
    #1 reset = 1'b1;
    #1;
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_grid_we", 32'(grid_we), 32'd0);
    check("midrst_gen", 32'(gen_count), 32'd0);
    mode = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    run_cycles(3, 2'd0, 2'd0, 1'b1, we_n, first);
    check("postrst_active", 32'(active), 32'd0);
    check("postrst_we_cnt", 32'(we_n), 32'd0);

    // Seed then run
    run_cycles(3, 2'd3, 2'd0, 1'b1, we_n, first);
    check("seed_we_cnt", 32'(we_n), 32'd3);
    check("seed_active", 32'(active), 32'd3);
    check("seed_gen", 32'(gen_count), 32'd0);
    run_cycles(20, 2'd1, 2'd0, 1'b1, we_n, first);
    check("run_we_cnt", 32'(we_n), 32'd4);
    check("run_first_load", 32'(first), 32'd5);
    check("run_gen4", 32'(gen_count), 32'd4);
    run_cycles(2, 2'd0, 2'd0, 1'b1, we_n, first);

    // Speed lowered mid-period
    run_cycles(11, 2'd1, 2'd2, 1'b1, we_n, first);
    check("slow_we_cnt", 32'(we_n), 32'd0);
    run_cycles(9, 2'd1, 2'd0, 1'b1, we_n, first);
    check("fast_we_cnt", 32'(we_n), 32'd3);
    check("fast_first_load", 32'(first), 32'd0);
    check("fast_gen", 32'(gen_count), 32'd7);
    run_cycles(2, 2'd0, 2'd0, 1'b1, we_n, first);

    // Single step twice
    apply_reset();
    step = 1'b1;
    @(posedge clk); @(negedge clk);
    step = 1'b0;
    check("step_active", 32'(active), 32'd1);
    check("step_grid_we", 32'(grid_we), 32'd1);
    check("step_gen_before", 32'(gen_count), 32'd0);
    @(posedge clk); @(negedge clk);
    check("step_gen1", 32'(gen_count), 32'd1);
    check("step_idle_active", 32'(active), 32'd0);
    step = 1'b1;
    @(posedge clk); @(negedge clk);
    step = 1'b0;
    @(posedge clk); @(negedge clk);
    check("step_gen2", 32'(gen_count), 32'd2);

    // gen_count wrap and exit on the tick edge
    apply_reset();
    run_cycles(61, 2'd1, 2'd0, 1'b1, we_n, first);
    check("wrap_gen15", 32'(gen_count), 32'd15);
    run_cycles(4, 2'd1, 2'd0, 1'b1, we_n, first);
    check("wrap_gen0", 32'(gen_count), 32'd0);
    check("wrap_we_cnt", 32'(we_n), 32'd1);
    run_cycles(3, 2'd1, 2'd0, 1'b1, we_n, first);
    run_cycles(2, 2'd0, 2'd0, 1'b1, we_n, first);
    check("exit_we_cnt", 32'(we_n), 32'd0);
    check("exit_gen", 32'(gen_count), 32'd0);

    // Static grid at a tick
    apply_reset();
    run_cycles(5, 2'd1, 2'd0, 1'b0, we_n, first);
`ifdef LIFE_FREEZE_DETECT_EN
    check("frz_we_cnt", 32'(we_n), 32'd0);
    check("frz_active", 32'(active), 32'd0);
    check("frz_frozen", 32'(frozen), 32'd1);
    check("frz_gen", 32'(gen_count), 32'd0);
`else
    check("nofrz_we_cnt", 32'(we_n), 32'd1);
    check("nofrz_active", 32'(active), 32'd1);
    check("nofrz_frozen", 32'(frozen), 32'd0);
    check("nofrz_gen", 32'(gen_count), 32'd1);
`endif
    run_cycles(2, 2'd3, 2'd0, 1'b1, we_n, first);
    check("reseed_frozen", 32'(frozen), 32'd0);
    check("reseed_active", 32'(active), 32'd3);

    // Randomized traffic, model compared every cycle
    apply_reset();
    for (int blk = 0; blk < 200; blk++) begin
      int len;
      mode = mode_tab[$urandom_range(0, 5)];
      speed = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        step = ($urandom_range(0, 5) == 0);
        grid_changed = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 400) == 0) begin
          #1 reset = 1'b1;
          #2 reset = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
